// File: rtl/button_event_ctrl_pkg.sv
// Shared constants and event record for the button event controller.
package button_event_ctrl_pkg;

  localparam int unsigned EVT_IDW = 2;

  // Default auto-repeat timing at 50 MHz: 10 ms initial hold, 2 ms repeat.
  localparam int unsigned DEF_HOLD_CYCLES   = 500000;
  localparam int unsigned DEF_REPEAT_CYCLES = 100000;

  typedef struct packed {
    logic               rep;
    logic [EVT_IDW-1:0] id;
  } evt_t;

endpackage

// File: rtl/button_event_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first request at or after ptr.
module rr_arbiter #(
  parameter int unsigned NBTN = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic [NBTN-1:0] req,
  input  logic [IDW-1:0]  ptr,
  input  logic            en,
  output logic            gnt_valid,
  output logic [IDW-1:0]  gnt_idx
);

  int unsigned idx;

  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    idx       = 0;
    for (int unsigned k = 0; k < NBTN; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NBTN) idx = idx - NBTN;
      if (en && !gnt_valid && req[idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/button_event_ctrl.sv
// Turns debounced button levels into an arbitrated stream of press/repeat events.
module button_event_ctrl
  import button_event_ctrl_pkg::*;
#(
  parameter int unsigned NBTN          = 4,
  parameter int unsigned IDW           = EVT_IDW,
  parameter int unsigned REPEAT_EN     = 1,
  parameter int unsigned HOLD_CYCLES   = DEF_HOLD_CYCLES,
  parameter int unsigned REPEAT_CYCLES = DEF_REPEAT_CYCLES,
  parameter int unsigned CW            = 20
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NBTN-1:0] btn_level,
  output logic            evt_valid,
  input  logic            evt_ready,
  output logic [IDW-1:0]  evt_id,
  output logic            evt_repeat,
  output logic [NBTN-1:0] overflow,
  input  logic [NBTN-1:0] ovf_clr
);

  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] RELOAD    = CW'(HOLD_CYCLES - REPEAT_CYCLES);

  logic [NBTN-1:0] btn_q;
  logic [NBTN-1:0] pending;
  logic [NBTN-1:0] pend_rep;
  logic [IDW-1:0]  rr_ptr;
  logic            slot_free;
  logic            gnt_valid;
  logic [IDW-1:0]  gnt_idx;

  assign slot_free = !evt_valid || evt_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) btn_q <= '0;
    else     btn_q <= btn_level;
  end

  for (genvar i = 0; i < NBTN; i++) begin : g_btn
    logic [CW-1:0] cnt;
    logic          press;
    logic          fire;
    logic          evt;
    logic          granted;
    logic          pend_r;
    logic          rep_r;
    logic          ovf_r;

    assign press   = btn_level[i] & ~btn_q[i];
    assign fire    = (REPEAT_EN != 0) && btn_level[i] && !press && (cnt == HOLD_LAST);
    assign evt     = press | fire;
    assign granted = gnt_valid && (gnt_idx == IDW'(i));

    always_ff @(posedge clk or posedge rst) begin
      if (rst)                         cnt <= '0;
      else if (!btn_level[i] || press) cnt <= '0;
      else if (REPEAT_EN != 0)         cnt <= (cnt == HOLD_LAST) ? RELOAD : cnt + 1'b1;
    end

    // A new event while the previous one is still waiting is dropped; a grant
    // in the same cycle frees the slot so the new event takes its place.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        pend_r <= 1'b0;
        rep_r  <= 1'b0;
        ovf_r  <= 1'b0;
      end else begin
        if (evt && !(pend_r && !granted)) begin
          pend_r <= 1'b1;
          rep_r  <= fire;
        end else if (granted) begin
          pend_r <= 1'b0;
        end
        if (evt && pend_r && !granted) ovf_r <= 1'b1;
        else if (ovf_clr[i])           ovf_r <= 1'b0;
      end
    end

    assign pending[i]  = pend_r;
    assign pend_rep[i] = rep_r;
    assign overflow[i] = ovf_r;
  end

  rr_arbiter #(
    .NBTN (NBTN),
    .IDW  (IDW)
  ) u_arb (
    .req       (pending),
    .ptr       (rr_ptr),
    .en        (slot_free),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      evt_valid  <= 1'b0;
      evt_id     <= '0;
      evt_repeat <= 1'b0;
      rr_ptr     <= '0;
    end else if (slot_free) begin
      if (gnt_valid) begin
        evt_valid  <= 1'b1;
        evt_id     <= gnt_idx;
        evt_repeat <= pend_rep[gnt_idx];
        rr_ptr     <= (gnt_idx == IDW'(NBTN - 1)) ? '0 : gnt_idx + IDW'(1);
      end else begin
        evt_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_button_event_ctrl.sv
// Directed self-checking bench for button_event_ctrl with short repeat timing.
module tb_button_event_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] btn_level;
  logic       evt_valid;
  logic       evt_ready;
  logic [1:0] evt_id;
  logic       evt_repeat;
  logic [3:0] overflow;
  logic [3:0] ovf_clr;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  button_event_ctrl #(
    .NBTN          (4),
    .IDW           (2),
    .REPEAT_EN     (1),
    .HOLD_CYCLES   (10),
    .REPEAT_CYCLES (4),
    .CW            (20)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_level  (btn_level),
    .evt_valid  (evt_valid),
    .evt_ready  (evt_ready),
    .evt_id     (evt_id),
    .evt_repeat (evt_repeat),
    .overflow   (overflow),
    .ovf_clr    (ovf_clr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; btn_level = 4'b0010; evt_ready = 1'b0; ovf_clr = 4'b0000;
    tick(); tick();
    n_cmp++;
    if ({evt_valid, evt_id, evt_repeat, overflow} !== 8'h00) begin
      $display("FAIL reset_outputs got=%h exp=00", {evt_valid, evt_id, evt_repeat, overflow}); n_bad++;
    end
    rst = 1'b0;
    tick();
    n_cmp++;
    if (evt_valid !== 1'b0) begin $display("FAIL reset_edge1_valid got=%b exp=0", evt_valid); n_bad++; end
    tick();
    n_cmp++;
    if ({evt_valid, evt_id, evt_repeat} !== 4'b1_01_0) begin
      $display("FAIL reset_held_evt got=%b exp=1010", {evt_valid, evt_id, evt_repeat}); n_bad++;
    end
    evt_ready = 1'b1; btn_level = 4'b0000;
    tick();
    n_cmp++;
    if (evt_valid !== 1'b0) begin $display("FAIL reset_evt_accept got=%b exp=0", evt_valid); n_bad++; end
    // Fresh reset so the round-robin pointer starts at 0.
    rst = 1'b1; tick(); rst = 1'b0; tick();
  endtask

  task automatic do_pair(input logic [3:0] btns, input logic [1:0] first, input logic [1:0] second);
    btn_level = btns;
    tick();
    btn_level = 4'b0000;
    n_cmp++;
    if (evt_valid !== 1'b0) begin $display("FAIL rr_lat valid got=%b exp=0", evt_valid); n_bad++; end
    tick();
    n_cmp++;
    if ({evt_valid, evt_id, evt_repeat} !== {1'b1, first, 1'b0}) begin
      $display("FAIL rr_first got=%b exp=%b", {evt_valid, evt_id, evt_repeat}, {1'b1, first, 1'b0}); n_bad++;
    end
    tick();
    n_cmp++;
    if ({evt_valid, evt_id, evt_repeat} !== {1'b1, second, 1'b0}) begin
      $display("FAIL rr_second got=%b exp=%b", {evt_valid, evt_id, evt_repeat}, {1'b1, second, 1'b0}); n_bad++;
    end
    tick();
    n_cmp++;
    if (evt_valid !== 1'b0) begin $display("FAIL rr_idle valid got=%b exp=0", evt_valid); n_bad++; end
  endtask

  task automatic test_round_robin();
    evt_ready = 1'b1;
    do_pair(4'b0101, 2'd0, 2'd2);  // ptr 0 -> 3
    do_pair(4'b0101, 2'd0, 2'd2);  // ptr 3 wraps -> 3
    do_pair(4'b1010, 2'd3, 2'd1);  // ptr 3 -> 2
    do_pair(4'b0101, 2'd2, 2'd0);  // ptr 2 -> 1
  endtask

  task automatic test_repeat();
    logic exp_v;
    evt_ready = 1'b1;
    btn_level = 4'b1000;
    tick();
    for (int c = 1; c <= 34; c++) begin
      tick();
      exp_v = (c == 1) || (c == 11) || (c == 15) || (c == 19) || (c == 23) || (c == 27);
      n_cmp++;
      if (evt_valid !== exp_v) begin
        $display("FAIL repeat_valid c=%0d got=%b exp=%b", c, evt_valid, exp_v); n_bad++;
      end
      if (exp_v) begin
        n_cmp++;
        if ({evt_id, evt_repeat} !== {2'd3, (c != 1)}) begin
          $display("FAIL repeat_evt c=%0d got=%b exp=%b", c, {evt_id, evt_repeat}, {2'd3, (c != 1)}); n_bad++;
        end
      end
      if (c == 29) btn_level = 4'b0000;
    end
  endtask

  task automatic test_overflow();
    evt_ready = 1'b0;
    for (int p = 0; p < 3; p++) begin
      btn_level = 4'b0010; tick();
      btn_level = 4'b0000; tick();
    end
    n_cmp++;
    if (overflow !== 4'b0010) begin $display("FAIL ovf_set got=%b exp=0010", overflow); n_bad++; end
    n_cmp++;
    if ({evt_valid, evt_id, evt_repeat} !== 4'b1_01_0) begin
      $display("FAIL ovf_held got=%b exp=1010", {evt_valid, evt_id, evt_repeat}); n_bad++;
    end
    evt_ready = 1'b1;
    tick();
    n_cmp++;
    if ({evt_valid, evt_id, evt_repeat} !== 4'b1_01_0) begin
      $display("FAIL ovf_second got=%b exp=1010", {evt_valid, evt_id, evt_repeat}); n_bad++;
    end
    tick();
    n_cmp++;
    if (evt_valid !== 1'b0) begin $display("FAIL ovf_no_third got=%b exp=0", evt_valid); n_bad++; end
    n_cmp++;
    if (overflow !== 4'b0010) begin $display("FAIL ovf_sticky got=%b exp=0010", overflow); n_bad++; end
    ovf_clr = 4'b0010; tick(); ovf_clr = 4'b0000;
    n_cmp++;
    if (overflow !== 4'b0000) begin $display("FAIL ovf_clr got=%b exp=0000", overflow); n_bad++; end
  endtask

  task automatic test_hold_stable();
    evt_ready = 1'b0;
    btn_level = 4'b0100; tick();
    btn_level = 4'b0000; tick();
    for (int c = 0; c < 5; c++) begin
      if (c == 1) btn_level = 4'b0001;
      if (c == 2) btn_level = 4'b0000;
      n_cmp++;
      if ({evt_valid, evt_id, evt_repeat} !== 4'b1_10_0) begin
        $display("FAIL hold_stable c=%0d got=%b exp=1100", c, {evt_valid, evt_id, evt_repeat}); n_bad++;
      end
      tick();
    end
    evt_ready = 1'b1;
    tick();
    n_cmp++;
    if ({evt_valid, evt_id, evt_repeat} !== 4'b1_00_0) begin
      $display("FAIL back_to_back got=%b exp=1000", {evt_valid, evt_id, evt_repeat}); n_bad++;
    end
    tick();
    n_cmp++;
    if (evt_valid !== 1'b0) begin $display("FAIL hold_drain got=%b exp=0", evt_valid); n_bad++; end
  endtask

  task automatic test_reset_mid();
    logic seen;
    evt_ready = 1'b0;
    btn_level = 4'b0001; tick();
    btn_level = 4'b0000; tick();
    btn_level = 4'b1100; tick();
    btn_level = 4'b0000;
    n_cmp++;
    if (evt_valid !== 1'b1) begin $display("FAIL mid_pre_valid got=%b exp=1", evt_valid); n_bad++; end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({evt_valid, evt_id, evt_repeat, overflow} !== 8'h00) begin
      $display("FAIL mid_async_clear got=%h exp=00", {evt_valid, evt_id, evt_repeat, overflow}); n_bad++;
    end
    tick();
    rst = 1'b0;
    evt_ready = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (evt_valid) seen = 1'b1;
    end
    n_cmp++;
    if (seen !== 1'b0) begin $display("FAIL mid_no_events got=%b exp=0", seen); n_bad++; end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_repeat();
    test_overflow();
    test_hold_stable();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
